riscv_exmem_stage: RTL and testbench
====================================

Name: riscv_exmem_stage

Overview:
- Pipeline stage directly downstream of the integer compute unit. Captures its 64-bit result and branch flag, plus the memory-stage control fields, into the EX/MEM register.
- Sequences multi-cycle multiply operations:
  - stalls the upstream pipeline until the multiplier's valid pulse arrives;
  - buffers the product if the memory stage is stalled;
  - aborts cleanly on flush or timeout.

Parameters:
- XLEN, 64, datapath width of result, store data and PC.
- MUL_TIMEOUT, 16, maximum WAIT_MUL cycles before abort; legal range 2..255.

Ports:
- i_riscv_exm_clk  in  1  clock
- i_riscv_exm_rst  in  1  synchronous active-high reset
- i_riscv_exm_valid  in  1  EX holds a live instruction this cycle
- i_riscv_exm_funcsel  in  2  compute-unit select; 2'b00 = multiply (multi-cycle), other values single-cycle
- i_riscv_exm_result  in  XLEN  compute-unit result
- i_riscv_exm_mulvalid  in  1  multiplier product-valid pulse
- i_riscv_exm_branchtaken  in  1  branch resolution from EX
- i_riscv_exm_rs2data  in  XLEN  store data
- i_riscv_exm_pc  in  XLEN  instruction PC
- i_riscv_exm_rdaddr  in  5  destination register
- i_riscv_exm_regwrite / i_riscv_exm_memwrite / i_riscv_exm_memread  in  1 each  control
- i_riscv_exm_memwidth  in  3  load/store funct3
- i_riscv_exm_flush  in  1  kill EX instruction
- i_riscv_exm_memstall  in  1  MEM cannot accept
- o_riscv_exm_stall  out  1  hold IF/ID/EX (combinational)
- o_riscv_exm_valid  out  1  MEM-stage entry valid
- o_riscv_exm_result, o_riscv_exm_rs2data, o_riscv_exm_pc  out  XLEN  registered copies
- o_riscv_exm_rdaddr  out  5; o_riscv_exm_memwidth  out  3
- o_riscv_exm_regwrite, o_riscv_exm_memwrite, o_riscv_exm_memread, o_riscv_exm_branchtaken  out  1 each
- o_riscv_exm_timeout  out  1  one-cycle pulse on multiply abort

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0;
  - all registered outputs 0;
  - o_riscv_exm_stall=0, o_riscv_exm_timeout=0.
- States: IDLE, WAIT_MUL, HOLD.
- IDLE:
  - memstall=1: output register holds; stall=1; inputs ignored.
  - Otherwise, valid=1 and flush=1: bubble (out valid=0 next edge).
  - Otherwise, valid=1 and funcsel!=00: capture all fields next edge, out valid=1, latency 1.
  - Otherwise, valid=1 and funcsel=00:
    - mulvalid=1 same cycle: capture as single-cycle.
    - mulvalid=0: latch control/pc/rs2/rd shadow regs; stall=1 combinationally this cycle; out valid=0 next edge; counter=1; go WAIT_MUL.
  - Otherwise (valid=0): out valid=0 next edge.
- WAIT_MUL:
  - stall=1 unless the exit condition below holds this cycle; out valid=0 while waiting.
  - flush=1 (highest priority): go IDLE, out valid=0, stall=0, no timeout.
  - Otherwise, mulvalid=1 and memstall=0: capture i_result plus shadow fields, out valid=1 next edge; stall=0 this cycle; go IDLE.
  - Otherwise, mulvalid=1 and memstall=1: product into holding reg, go HOLD, stall stays 1.
  - Otherwise, counter==MUL_TIMEOUT: timeout=1 for one cycle, out valid=0, go IDLE, stall=0 this cycle.
  - Otherwise counter+=1.
- HOLD:
  - stall=1.
  - When memstall=0: load holding product and shadow fields into outputs, out valid=1 next edge, go IDLE, stall=0 that cycle.
  - flush in HOLD discards the entry, go IDLE.
- memstall=1 in any state freezes the output register; it never drops a valid entry.
- mulvalid outside WAIT_MUL, or in IDLE without a multiply, is ignored.
- Flush never clears an already-registered MEM entry; it only kills the EX instruction.
- Reset mid-WAIT_MUL/HOLD: return to IDLE, drop shadow state, no timeout pulse.

Test Plan:
- ALU op: funcsel=10, result=0x1234, rd=5, regwrite=1 -> next cycle out valid=1, result=0x1234, rd=5, stall never asserted.
- Multiply, 4-cycle latency: funcsel=00, rd=7; mulvalid high 3 cycles later with result=0xFFFF_FFFF_0000_0001 -> stall=1 for cycles 0..2, low on cycle 3; out valid=1 with that result and rd=7 on the following edge.
- Mul done while MEM stalled: mulvalid with result=0x42 while memstall=1 for 2 cycles -> HOLD entered, stall stays 1; after memstall drops, out result=0x42 valid=1, exactly one valid entry.
- Flush during WAIT_MUL: flush pulse 2 cycles after issue, then late mulvalid -> no valid output, stall=0 after flush, mulvalid ignored.
- Timeout: multiply with no mulvalid, MUL_TIMEOUT=16 -> timeout pulses once 16 cycles after issue, out valid stays 0, FSM back in IDLE; the next ALU op completes in 1 cycle.
- Reset mid-WAIT_MUL: assert rst for 1 cycle -> all outputs 0, stall=0, state IDLE, no timeout pulse.

Source files
------------

// File: rtl/riscv_exmem_stage_if.sv
// EX -> EX/MEM -> MEM bundle: EX-side inputs, flow control and registered MEM-stage outputs.
// Latency: none (wiring only).
// Backpressure: carries i_riscv_exm_memstall in and o_riscv_exm_stall out.
// Ports: master = EX/MEM environment (drives i_*, reads o_*); slave = the stage (reads i_*, drives o_*).
interface riscv_exmem_stage_if #(
  parameter int XLEN = 64
);
  logic            i_riscv_exm_valid;
  logic [1:0]      i_riscv_exm_funcsel;
  logic [XLEN-1:0] i_riscv_exm_result;
  logic            i_riscv_exm_mulvalid;
  logic            i_riscv_exm_branchtaken;
  logic [XLEN-1:0] i_riscv_exm_rs2data;
  logic [XLEN-1:0] i_riscv_exm_pc;
  logic [4:0]      i_riscv_exm_rdaddr;
  logic            i_riscv_exm_regwrite;
  logic            i_riscv_exm_memwrite;
  logic            i_riscv_exm_memread;
  logic [2:0]      i_riscv_exm_memwidth;
  logic            i_riscv_exm_flush;
  logic            i_riscv_exm_memstall;

  logic            o_riscv_exm_stall;
  logic            o_riscv_exm_valid;
  logic [XLEN-1:0] o_riscv_exm_result;
  logic [XLEN-1:0] o_riscv_exm_rs2data;
  logic [XLEN-1:0] o_riscv_exm_pc;
  logic [4:0]      o_riscv_exm_rdaddr;
  logic [2:0]      o_riscv_exm_memwidth;
  logic            o_riscv_exm_regwrite;
  logic            o_riscv_exm_memwrite;
  logic            o_riscv_exm_memread;
  logic            o_riscv_exm_branchtaken;
  logic            o_riscv_exm_timeout;

  modport master (
    output i_riscv_exm_valid, i_riscv_exm_funcsel, i_riscv_exm_result, i_riscv_exm_mulvalid,
           i_riscv_exm_branchtaken, i_riscv_exm_rs2data, i_riscv_exm_pc, i_riscv_exm_rdaddr,
           i_riscv_exm_regwrite, i_riscv_exm_memwrite, i_riscv_exm_memread, i_riscv_exm_memwidth,
           i_riscv_exm_flush, i_riscv_exm_memstall,
    input  o_riscv_exm_stall, o_riscv_exm_valid, o_riscv_exm_result, o_riscv_exm_rs2data,
           o_riscv_exm_pc, o_riscv_exm_rdaddr, o_riscv_exm_memwidth, o_riscv_exm_regwrite,
           o_riscv_exm_memwrite, o_riscv_exm_memread, o_riscv_exm_branchtaken, o_riscv_exm_timeout
  );

  modport slave (
    input  i_riscv_exm_valid, i_riscv_exm_funcsel, i_riscv_exm_result, i_riscv_exm_mulvalid,
           i_riscv_exm_branchtaken, i_riscv_exm_rs2data, i_riscv_exm_pc, i_riscv_exm_rdaddr,
           i_riscv_exm_regwrite, i_riscv_exm_memwrite, i_riscv_exm_memread, i_riscv_exm_memwidth,
           i_riscv_exm_flush, i_riscv_exm_memstall,
    output o_riscv_exm_stall, o_riscv_exm_valid, o_riscv_exm_result, o_riscv_exm_rs2data,
           o_riscv_exm_pc, o_riscv_exm_rdaddr, o_riscv_exm_memwidth, o_riscv_exm_regwrite,
           o_riscv_exm_memwrite, o_riscv_exm_memread, o_riscv_exm_branchtaken, o_riscv_exm_timeout
  );
endinterface

// File: rtl/riscv_exmem_stage.sv
// EX/MEM pipeline register with multi-cycle multiply sequencing (IDLE / WAIT_MUL / HOLD).
// Latency: 1 cycle for single-cycle ops; multiply completes the edge after the mulvalid pulse (or after MEM releases).
// Backpressure: memstall freezes the output register and raises stall; stall also held while a multiply is pending.
// Ports: i_riscv_exm_clk / i_riscv_exm_rst (sync, active-high) plain; everything else via riscv_exmem_stage_if.slave.
module riscv_exmem_stage #(
  parameter int XLEN        = 64,
  parameter int MUL_TIMEOUT = 16
) (
  input logic                i_riscv_exm_clk,
  input logic                i_riscv_exm_rst,
  riscv_exmem_stage_if.slave exm
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MUL = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MUL_TIMEOUT);

  // Everything about an instruction except its compute result.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs2data;
    logic [4:0]      rdaddr;
    logic [2:0]      memwidth;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            branchtaken;
  } ctl_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] result;
    ctl_t            ctl;
  } ent_t;

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  ctl_t            shdw_q, shdw_d;     // fields of the multiply in flight
  logic [XLEN-1:0] hold_q, hold_d;     // product parked while MEM is stalled
  ent_t            out_q, out_d;       // the EX/MEM register itself

  ctl_t in_ctl;
  logic stall;
  logic timeout;

  always_comb begin
    in_ctl.pc          = exm.i_riscv_exm_pc;
    in_ctl.rs2data     = exm.i_riscv_exm_rs2data;
    in_ctl.rdaddr      = exm.i_riscv_exm_rdaddr;
    in_ctl.memwidth    = exm.i_riscv_exm_memwidth;
    in_ctl.regwrite    = exm.i_riscv_exm_regwrite;
    in_ctl.memwrite    = exm.i_riscv_exm_memwrite;
    in_ctl.memread     = exm.i_riscv_exm_memread;
    in_ctl.branchtaken = exm.i_riscv_exm_branchtaken;

    state_d = state_q;
    cnt_d   = cnt_q;
    shdw_d  = shdw_q;
    hold_d  = hold_q;
    out_d   = out_q;
    stall   = 1'b0;
    timeout = 1'b0;

    // The output register only moves when MEM can take it, so a valid
    // entry is never dropped or overwritten under memstall.
    if (!exm.i_riscv_exm_memstall) begin
      out_d.vld = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (exm.i_riscv_exm_memstall) begin
          stall = 1'b1;
        end else if (exm.i_riscv_exm_valid && !exm.i_riscv_exm_flush) begin
          // A multiply whose product is already valid behaves like a single-cycle op.
          if (exm.i_riscv_exm_funcsel != 2'b00 || exm.i_riscv_exm_mulvalid) begin
            out_d = '{vld: 1'b1, result: exm.i_riscv_exm_result, ctl: in_ctl};
          end else begin
            shdw_d  = in_ctl;
            cnt_d   = 8'd1;
            state_d = WAIT_MUL;
            stall   = 1'b1;
          end
        end
      end

      WAIT_MUL: begin
        stall = 1'b1;
        if (exm.i_riscv_exm_flush) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          stall   = 1'b0;
        end else if (exm.i_riscv_exm_mulvalid && !exm.i_riscv_exm_memstall) begin
          out_d   = '{vld: 1'b1, result: exm.i_riscv_exm_result, ctl: shdw_q};
          state_d = IDLE;
          cnt_d   = 8'd0;
          stall   = 1'b0;
        end else if (exm.i_riscv_exm_mulvalid) begin
          // The pulse is not repeated, so the product must be kept here.
          hold_d  = exm.i_riscv_exm_result;
          state_d = HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
          stall   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        stall = 1'b1;
        if (exm.i_riscv_exm_flush) begin
          state_d = IDLE;
          stall   = 1'b0;
        end else if (!exm.i_riscv_exm_memstall) begin
          out_d   = '{vld: 1'b1, result: hold_q, ctl: shdw_q};
          state_d = IDLE;
          stall   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Reset wins over everything, including a pending timeout in the same cycle.
    if (i_riscv_exm_rst) begin
      stall   = 1'b0;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge i_riscv_exm_clk) begin
    if (i_riscv_exm_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      shdw_q  <= '0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shdw_q  <= shdw_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign exm.o_riscv_exm_stall       = stall;
  assign exm.o_riscv_exm_timeout     = timeout;
  assign exm.o_riscv_exm_valid       = out_q.vld;
  assign exm.o_riscv_exm_result      = out_q.result;
  assign exm.o_riscv_exm_rs2data     = out_q.ctl.rs2data;
  assign exm.o_riscv_exm_pc          = out_q.ctl.pc;
  assign exm.o_riscv_exm_rdaddr      = out_q.ctl.rdaddr;
  assign exm.o_riscv_exm_memwidth    = out_q.ctl.memwidth;
  assign exm.o_riscv_exm_regwrite    = out_q.ctl.regwrite;
  assign exm.o_riscv_exm_memwrite    = out_q.ctl.memwrite;
  assign exm.o_riscv_exm_memread     = out_q.ctl.memread;
  assign exm.o_riscv_exm_branchtaken = out_q.ctl.branchtaken;

endmodule

// File: tb/tb_riscv_exmem_stage.sv
// Directed bench for riscv_exmem_stage: ALU path, multiply wait/hold/flush/timeout, reset mid-multiply.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: memstall driven directly from the vectors.
module tb_riscv_exmem_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_to   = 0;
  int   n_nostall = 0;

  riscv_exmem_stage_if #(.XLEN(XLEN)) exm_if ();

  riscv_exmem_stage #(.XLEN(XLEN), .MUL_TIMEOUT(16)) dut (
    .i_riscv_exm_clk (clk),
    .i_riscv_exm_rst (rst),
    .exm             (exm_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_op(input logic [1:0] fs, input logic [63:0] res, input logic [4:0] rd,
                          input logic [63:0] pc);
    exm_if.i_riscv_exm_valid    = 1'b1;
    exm_if.i_riscv_exm_funcsel  = fs;
    exm_if.i_riscv_exm_result   = res;
    exm_if.i_riscv_exm_rdaddr   = rd;
    exm_if.i_riscv_exm_pc       = pc;
    exm_if.i_riscv_exm_rs2data  = pc + 64'h8;
    exm_if.i_riscv_exm_regwrite = 1'b1;
  endtask

  initial begin
    exm_if.i_riscv_exm_valid       = 1'b0;
    exm_if.i_riscv_exm_funcsel     = 2'b10;
    exm_if.i_riscv_exm_result      = '0;
    exm_if.i_riscv_exm_mulvalid    = 1'b0;
    exm_if.i_riscv_exm_branchtaken = 1'b0;
    exm_if.i_riscv_exm_rs2data     = '0;
    exm_if.i_riscv_exm_pc          = '0;
    exm_if.i_riscv_exm_rdaddr      = '0;
    exm_if.i_riscv_exm_regwrite    = 1'b0;
    exm_if.i_riscv_exm_memwrite    = 1'b0;
    exm_if.i_riscv_exm_memread     = 1'b0;
    exm_if.i_riscv_exm_memwidth    = 3'b011;
    exm_if.i_riscv_exm_flush       = 1'b0;
    exm_if.i_riscv_exm_memstall    = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_valid",   64'(exm_if.o_riscv_exm_valid), 64'd0);
    check("rst_result",  exm_if.o_riscv_exm_result, 64'd0);
    check("rst_rd",      64'(exm_if.o_riscv_exm_rdaddr), 64'd0);
    check("rst_stall",   64'(exm_if.o_riscv_exm_stall), 64'd0);
    check("rst_timeout", 64'(exm_if.o_riscv_exm_timeout), 64'd0);

    // ALU op, latency 1
    tick();
    drive_op(2'b10, 64'h1234, 5'd5, 64'h100);
    settle();
    check("alu_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_valid = 1'b0;
    settle();
    check("alu_valid",  64'(exm_if.o_riscv_exm_valid), 64'd1);
    check("alu_result", exm_if.o_riscv_exm_result, 64'h1234);
    check("alu_rd",     64'(exm_if.o_riscv_exm_rdaddr), 64'd5);
    check("alu_rw",     64'(exm_if.o_riscv_exm_regwrite), 64'd1);
    check("alu_rs2",    exm_if.o_riscv_exm_rs2data, 64'h108);
    check("alu_stall2", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    settle();
    check("alu_bubble", 64'(exm_if.o_riscv_exm_valid), 64'd0);

    // memstall in IDLE freezes a valid entry and stalls
    drive_op(2'b01, 64'h10, 5'd1, 64'h180);
    tick();
    drive_op(2'b01, 64'h20, 5'd2, 64'h184);
    exm_if.i_riscv_exm_memstall = 1'b1;
    settle();
    check("ms_stall",  64'(exm_if.o_riscv_exm_stall), 64'd1);
    check("ms_valid",  64'(exm_if.o_riscv_exm_valid), 64'd1);
    tick();
    settle();
    check("ms_hold_res", exm_if.o_riscv_exm_result, 64'h10);
    check("ms_hold_vld", 64'(exm_if.o_riscv_exm_valid), 64'd1);
    exm_if.i_riscv_exm_memstall = 1'b0;
    settle();
    check("ms_release_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_valid = 1'b0;
    settle();
    check("ms_next_res", exm_if.o_riscv_exm_result, 64'h20);
    check("ms_next_rd",  64'(exm_if.o_riscv_exm_rdaddr), 64'd2);
    tick();

    // Multiply, product valid in cycle 3
    drive_op(2'b00, 64'h0, 5'd7, 64'h200);
    settle();
    check("mul_c0_stall", 64'(exm_if.o_riscv_exm_stall), 64'd1);
    tick(); settle();
    check("mul_c1_stall", 64'(exm_if.o_riscv_exm_stall), 64'd1);
    check("mul_c1_valid", 64'(exm_if.o_riscv_exm_valid), 64'd0);
    tick(); settle();
    check("mul_c2_stall", 64'(exm_if.o_riscv_exm_stall), 64'd1);
    tick();
    exm_if.i_riscv_exm_mulvalid = 1'b1;
    exm_if.i_riscv_exm_result   = 64'hFFFF_FFFF_0000_0001;
    settle();
    check("mul_c3_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_mulvalid = 1'b0;
    exm_if.i_riscv_exm_valid    = 1'b0;
    settle();
    check("mul_valid",  64'(exm_if.o_riscv_exm_valid), 64'd1);
    check("mul_result", exm_if.o_riscv_exm_result, 64'hFFFF_FFFF_0000_0001);
    check("mul_rd",     64'(exm_if.o_riscv_exm_rdaddr), 64'd7);
    check("mul_pc",     exm_if.o_riscv_exm_pc, 64'h200);
    tick();

    // Multiply done while MEM is stalled -> HOLD
    drive_op(2'b00, 64'h0, 5'd9, 64'h300);
    tick();
    exm_if.i_riscv_exm_mulvalid = 1'b1;
    exm_if.i_riscv_exm_result   = 64'h42;
    exm_if.i_riscv_exm_memstall = 1'b1;
    settle();
    check("hold_c1_stall", 64'(exm_if.o_riscv_exm_stall), 64'd1);
    tick();
    exm_if.i_riscv_exm_mulvalid = 1'b0;
    exm_if.i_riscv_exm_result   = 64'hDEAD;
    settle();
    check("hold_c2_stall", 64'(exm_if.o_riscv_exm_stall), 64'd1);
    check("hold_c2_valid", 64'(exm_if.o_riscv_exm_valid), 64'd0);
    tick();
    exm_if.i_riscv_exm_memstall = 1'b0;
    settle();
    check("hold_rel_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_valid = 1'b0;
    settle();
    check("hold_valid",  64'(exm_if.o_riscv_exm_valid), 64'd1);
    check("hold_result", exm_if.o_riscv_exm_result, 64'h42);
    check("hold_rd",     64'(exm_if.o_riscv_exm_rdaddr), 64'd9);
    tick(); settle();
    check("hold_single", 64'(exm_if.o_riscv_exm_valid), 64'd0);

    // Flush during WAIT_MUL, then a late mulvalid
    drive_op(2'b00, 64'h0, 5'd11, 64'h400);
    tick();
    tick();
    exm_if.i_riscv_exm_flush = 1'b1;
    settle();
    check("flush_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_flush    = 1'b0;
    exm_if.i_riscv_exm_valid    = 1'b0;
    exm_if.i_riscv_exm_mulvalid = 1'b1;
    exm_if.i_riscv_exm_result   = 64'h99;
    settle();
    check("flush_valid0", 64'(exm_if.o_riscv_exm_valid), 64'd0);
    tick();
    exm_if.i_riscv_exm_mulvalid = 1'b0;
    settle();
    check("flush_late_mv", 64'(exm_if.o_riscv_exm_valid), 64'd0);
    check("flush_no_to",   64'(exm_if.o_riscv_exm_timeout), 64'd0);
    tick();

    // Timeout: multiply never completes
    drive_op(2'b00, 64'h0, 5'd12, 64'h500);
    n_to = 0;
    n_nostall = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(); settle();
      if (exm_if.o_riscv_exm_timeout) n_to++;
      if (!exm_if.o_riscv_exm_stall) n_nostall++;
      if (exm_if.o_riscv_exm_valid) n_to++;
    end
    check("to_early",      64'(n_to), 64'd0);
    check("to_stall_held", 64'(n_nostall), 64'd0);
    tick(); settle();
    check("to_pulse", 64'(exm_if.o_riscv_exm_timeout), 64'd1);
    check("to_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_valid = 1'b0;
    settle();
    check("to_once",  64'(exm_if.o_riscv_exm_timeout), 64'd0);
    check("to_valid", 64'(exm_if.o_riscv_exm_valid), 64'd0);
    drive_op(2'b01, 64'h777, 5'd3, 64'h600);
    settle();
    check("to_alu_stall", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    exm_if.i_riscv_exm_valid = 1'b0;
    settle();
    check("to_alu_valid",  64'(exm_if.o_riscv_exm_valid), 64'd1);
    check("to_alu_result", exm_if.o_riscv_exm_result, 64'h777);
    tick();

    // Reset mid-WAIT_MUL
    drive_op(2'b00, 64'h0, 5'd13, 64'h700);
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("rmid_stall_in_rst", 64'(exm_if.o_riscv_exm_stall), 64'd0);
    tick();
    rst = 1'b0;
    exm_if.i_riscv_exm_valid    = 1'b0;
    exm_if.i_riscv_exm_mulvalid = 1'b1;
    exm_if.i_riscv_exm_result   = 64'h55;
    settle();
    check("rmid_valid",   64'(exm_if.o_riscv_exm_valid), 64'd0);
    check("rmid_result",  exm_if.o_riscv_exm_result, 64'd0);
    check("rmid_pc",      exm_if.o_riscv_exm_pc, 64'd0);
    check("rmid_rd",      64'(exm_if.o_riscv_exm_rdaddr), 64'd0);
    check("rmid_stall",   64'(exm_if.o_riscv_exm_stall), 64'd0);
    check("rmid_timeout", 64'(exm_if.o_riscv_exm_timeout), 64'd0);
    n_to = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); settle();
      if (exm_if.o_riscv_exm_timeout || exm_if.o_riscv_exm_valid || exm_if.o_riscv_exm_stall) n_to++;
    end
    check("rmid_quiet", 64'(n_to), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
